// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared encodings for the counter sweep controller.
// Holds FSM state encodings and sweep mode constants.
package sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN_UP   = 3'd2,
        ST_RUN_DOWN = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

endpackage

// File: rtl/up_down_counter_en.sv
// N-bit up/down counter with synchronous load and count enable.
// Ports: clk, rst_n, en, load, up_down, load_val -> count_o.
module up_down_counter_en #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic         up_down,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count_o
);

    logic [N-1:0] count_q;

    // Load wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en) begin
            count_q <= up_down ? count_q + N'(1) : count_q - N'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweeps a counter between lo and hi in UP, DOWN or BOUNCE mode
// for a programmed number of passes. Ports: start/abort/config in;
// count, up_down, busy, done, cfg_err, pass_cnt out.
module counter_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int N      = 4,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [N-1:0]      lo,
    input  logic [N-1:0]      hi,
    input  logic [PASS_W-1:0] passes,
    output logic [N-1:0]      count,
    output logic              up_down,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [PASS_W-1:0] pass_cnt
);

    state_e            state_q;
    mode_e             mode_q;
    logic [N-1:0]      lo_q;
    logic [N-1:0]      hi_q;
    logic [PASS_W-1:0] passes_q;
    logic [PASS_W-1:0] pass_cnt_q;
    logic              up_down_q;
    logic              busy_q;
    logic              done_q;
    logic              cfg_err_q;

    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_dir;
    logic [N-1:0]      cnt_val;
    logic              at_hi;
    logic              at_lo;
    logic              last;
    logic              pass_evt;

    assign at_hi = (count == hi_q);
    assign at_lo = (count == lo_q);

    // Completing pass is the final one only for a nonzero pass budget.
    assign last = (passes_q != '0) &&
                  (PASS_W'(pass_cnt_q + 1'b1) == passes_q);

    // BOUNCE turning at hi is only half a pass.
    assign pass_evt = !abort &&
        ((state_q == ST_RUN_UP && at_hi && mode_q != MODE_BOUNCE) ||
         (state_q == ST_RUN_DOWN && at_lo));

    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_dir  = up_down_q;
        cnt_val  = lo_q;
        if (!abort) begin
            unique case (state_q)
                ST_LOAD: begin
                    cnt_load = 1'b1;
                    cnt_val  = (mode_q == MODE_DOWN) ? hi_q : lo_q;
                end
                ST_RUN_UP: begin
                    if (!at_hi) begin
                        cnt_en  = 1'b1;
                        cnt_dir = 1'b1;
                    end else if (mode_q == MODE_BOUNCE) begin
                        cnt_load = 1'b1;
                        cnt_val  = hi_q - N'(1);
                    end else if (!last) begin
                        cnt_load = 1'b1;
                        cnt_val  = lo_q;
                    end
                end
                ST_RUN_DOWN: begin
                    if (!at_lo) begin
                        cnt_en  = 1'b1;
                        cnt_dir = 1'b0;
                    end else if (!last) begin
                        cnt_load = 1'b1;
                        cnt_val  = (mode_q == MODE_DOWN) ? hi_q
                                                         : lo_q + N'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_UP;
            lo_q       <= '0;
            hi_q       <= '0;
            passes_q   <= '0;
            pass_cnt_q <= '0;
            up_down_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (mode == MODE_RSVD || lo >= hi) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                mode_q     <= mode_e'(mode);
                                lo_q       <= lo;
                                hi_q       <= hi;
                                passes_q   <= passes;
                                pass_cnt_q <= '0;
                                state_q    <= ST_LOAD;
                                busy_q     <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (mode_q == MODE_DOWN) begin
                            up_down_q <= 1'b0;
                            state_q   <= ST_RUN_DOWN;
                        end else begin
                            up_down_q <= 1'b1;
                            state_q   <= ST_RUN_UP;
                        end
                    end
                    ST_RUN_UP: begin
                        if (at_hi) begin
                            if (mode_q == MODE_BOUNCE) begin
                                up_down_q <= 1'b0;
                                state_q   <= ST_RUN_DOWN;
                            end else if (last) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN_DOWN: begin
                        if (at_lo) begin
                            if (last) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else if (mode_q == MODE_BOUNCE) begin
                                up_down_q <= 1'b1;
                                state_q   <= ST_RUN_UP;
                            end
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
                if (pass_evt && pass_cnt_q != '1) begin
                    pass_cnt_q <= pass_cnt_q + 1'b1;
                end
            end
        end
    end

    up_down_counter_en #(.N(N)) u_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .en       (cnt_en),
        .load     (cnt_load),
        .up_down  (cnt_dir),
        .load_val (cnt_val),
        .count_o  (count)
    );

    assign up_down  = up_down_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;
    assign pass_cnt = pass_cnt_q;

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer that owns an N-bit up/down counter and sweeps it between programmable limits lo and hi.
- Sweep modes: repeated up-ramps, repeated down-ramps, or bounce (triangle).
- Runs for a programmed number of passes, then signals completion.
- Sits between the register/config layer and any consumer of the counter value, such as a PWM or address generator.

Parameters:
- N, 4: counter width. Also the width of lo, hi and count.
- PASS_W, 4: width of the pass counter and the passes input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  1-cycle request that samples the config inputs. Only accepted in IDLE.
- abort  input  1  stops any sweep; state goes to IDLE on the next edge.
- mode  input  2  00 = UP, 01 = DOWN, 10 = BOUNCE, 11 = reserved.
- lo  input  N  lower limit, unsigned.
- hi  input  N  upper limit, unsigned. Must satisfy hi > lo.
- passes  input  PASS_W  number of passes to run; 0 = run until abort.
- count  output  N  current counter value.
- up_down  output  1  current direction: 1 = up, 0 = down.
- busy  output  1  high in LOAD, RUN_UP and RUN_DOWN.
- done  output  1  1-cycle pulse when the final pass completes.
- cfg_err  output  1  1-cycle pulse when a start is rejected.
- pass_cnt  output  PASS_W  number of passes completed in the current sweep.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE; count, pass_cnt, done, cfg_err = 0; up_down = 1; busy = 0. Latched config is cleared to 0.
- States: IDLE, LOAD, RUN_UP, RUN_DOWN, DONE.
- IDLE:
  - count holds its value.
  - On an edge with start = 1, config is rejected if mode = 11 or lo >= hi. In that case cfg_err = 1 for the following cycle and state stays IDLE.
  - Otherwise mode, lo, hi and passes are latched, pass_cnt = 0, and state goes to LOAD.
- LOAD (1 cycle):
  - UP or BOUNCE: count <= lo, up_down <= 1, next state RUN_UP.
  - DOWN: count <= hi, up_down <= 0, next state RUN_DOWN.
- RUN_UP, while count != hi: count <= count + 1 on each edge.
- RUN_UP, when count == hi:
  - UP mode: a pass completes. Either go to the final-pass action (below) or set count <= lo and stay in RUN_UP.
  - BOUNCE mode: count <= hi - 1, up_down <= 0, next state RUN_DOWN. No pass completes here.
- RUN_DOWN, while count != lo: count <= count - 1 on each edge.
- RUN_DOWN, when count == lo: a pass completes.
  - DOWN mode: either the final-pass action, or count <= hi and stay in RUN_DOWN.
  - BOUNCE mode: either the final-pass action, or count <= lo + 1, up_down <= 1, next state RUN_UP.
- On every pass completion: pass_cnt <= pass_cnt + 1, saturating at all-ones.
  - The pass is final when passes != 0 and pass_cnt + 1 == passes.
  - Final-pass action: count holds at the limit value, next state DONE.
- DONE (1 cycle): done = 1, busy = 0, then IDLE. count and pass_cnt hold until the next accepted start.
- Sweeps with passes = 0 never enter DONE. pass_cnt saturates and the counter keeps wrapping or bouncing.
- Change rules:
  - Config inputs are don't-care after the start edge; latched copies are used.
  - start while busy or in DONE is ignored, with no cfg_err.
- abort:
  - Has priority over every transition, including start in IDLE.
  - The next state is IDLE, count freezes at its current value, and done is not pulsed.
- Arithmetic is unsigned modulo 2^N. Wrap-around never occurs inside a sweep because the limits are checked first. The full range lo = 0, hi = 2^N - 1 is legal.
- done, cfg_err and busy are registered outputs with no combinational paths from inputs.

Decomposition:
- Shared package or header sweep_pkg holds:
  - state encodings (IDLE = 0, LOAD = 1, RUN_UP = 2, RUN_DOWN = 3, DONE = 4, 3 bits);
  - mode constants MODE_UP, MODE_DOWN, MODE_BOUNCE.
- One sub-module, up_down_counter_en: N-bit counter with en, load and load_val, plus up_down.
  - FSM drives load, en and direction; the counter holds count.
  - Priority inside the counter: reset, then load, then en.

Test Plan:
1. UP mode, lo = 2, hi = 5, passes = 1, start pulse → LOAD, then count 2, 3, 4, 5 on consecutive cycles. done pulses once the cycle after count = 5, then IDLE; busy was high for 5 cycles; count holds 5.
2. BOUNCE mode, lo = 1, hi = 3, passes = 2 → count 1, 2, 3, 2, 1, 2, 3, 2, 1. pass_cnt steps to 1 then 2. A single done pulse appears; up_down toggles at 3 and at 1.
3. DOWN mode, lo = 0, hi = 15, passes = 2 → count 15 down to 0, reload to 15, 15 down to 0 again, then done. Covers the full range with no wrap through 0 to 15 by arithmetic.
4. Rejected starts:
   - lo = 5, hi = 5: cfg_err pulses 1 cycle, busy stays 0, count unchanged.
   - mode = 11: same result.
   - start while busy: ignored, no cfg_err.
5. UP mode, lo = 0, hi = 9, passes = 0:
   - Run about 40 cycles, then pulse abort at count = 6: next cycle IDLE, count = 6, no done pulse, pass_cnt = 4.
   - Repeat with abort and start asserted in the same cycle: abort wins, state stays IDLE.
6. Reset mid-sweep: assert rst = 0 between clock edges while in RUN_DOWN → count, pass_cnt and busy clear immediately without waiting for an edge. After release, a new start behaves as in scenario 1.
